fp_norm_round_stage: RTL and testbench

FP_NORM_ROUND_STAGE -- requirements
Module: fp_norm_round_stage

---
 rtl/fp_norm_round_stage.sv | 100 ++++++++++
 tb/tb_fp_norm_round_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fp_norm_round_stage.sv
// fp_norm_round_stage: two-stage elastic normalize (S1) and round-to-nearest-even/pack (S2) pipeline.
module fp_norm_round_stage #(
  parameter int DataSize     = 32,
  parameter int FractionSize = 23,
  parameter int ExponentSize = 8,
  parameter int RoundingSize = 27
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [RoundingSize-1:0] AdderResult,
  input  logic                    EffCarry,
  input  logic [4:0]              NormShifts,
  input  logic [ExponentSize-1:0] ExpIn,
  input  logic                    SignIn,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [DataSize-1:0]     Result,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    Inexact
);
  localparam int ExpW = ExponentSize + 2;
  logic                    s1_valid_q, s1_zero_q, s1_sign_q;
  logic [RoundingSize-1:0] s1_mant_q, s1_mant_d;
  logic signed [ExpW-1:0]  s1_exp_q, s1_exp_d;
  logic                    s1_zero_d;
  logic                    out_valid_q;
  logic [DataSize-1:0]     result_q, result_d;
  logic                    ovf_q, unf_q, inx_q, ovf_d, unf_d, inx_d;
  logic                    s2_adv;
  logic [23:0]             m;
  logic                    g, r, s, rnd, ovf, unf;
  logic [24:0]             sum;
  logic signed [ExpW-1:0]  e;
  logic [FractionSize-1:0] frac;
  assign s2_adv  = ~out_valid_q | OutReady;
  assign InReady = ~s1_valid_q | s2_adv;
  always_comb begin
    s1_zero_d = ~EffCarry & (NormShifts >= 5'd24);
    s1_mant_d = EffCarry  ? {1'b1, AdderResult[26:2], |AdderResult[1:0]} :
                s1_zero_d ? AdderResult : AdderResult << NormShifts;
    s1_exp_d  = EffCarry  ? $signed({2'b00, ExpIn}) + 10'sd1 :
                            $signed({2'b00, ExpIn}) - $signed({5'b00000, NormShifts});
  end
  // A hidden bit of 0 after rounding means S1 could not normalize; flush it like an underflow.
  always_comb begin
    m        = s1_mant_q[26:3];
    g        = s1_mant_q[2];
    r        = s1_mant_q[1];
    s        = s1_mant_q[0];
    rnd      = g & (r | s | m[0]);
    sum      = {1'b0, m} + {24'b0, rnd};
    frac     = sum[24] ? '0 : sum[22:0];
    e        = s1_exp_q + $signed({9'b0, sum[24]});
    ovf      = e >= 10'sd255;
    unf      = (e <= 10'sd0) | ~(sum[24] | sum[23]);
    result_d = s1_zero_q ? '0 :
               ovf       ? {s1_sign_q, 8'hFF, 23'h0} :
               unf       ? {s1_sign_q, 31'h0} : {s1_sign_q, e[7:0], frac};
    ovf_d    = ~s1_zero_q & ovf;
    unf_d    = ~s1_zero_q & ~ovf & unf;
    inx_d    = g | r | s | ovf_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      if (InReady) s1_valid_q <= InValid;
      if (InReady && InValid) begin
        s1_zero_q <= s1_zero_d;
        s1_sign_q <= SignIn & ~s1_zero_d;
        s1_mant_q <= s1_mant_d;
        s1_exp_q  <= s1_exp_d;
      end
      if (s2_adv) out_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        inx_q    <= inx_d;
      end
    end
  end
  assign OutValid  = out_valid_q;
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign Inexact   = inx_q;
endmodule

// File: tb/tb_fp_norm_round_stage.sv
// tb_fp_norm_round_stage: directed vectors with hand-computed results, backpressure and mid-flight reset.
module tb_fp_norm_round_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [26:0] AdderResult = '0;
  logic        EffCarry = 1'b0;
  logic [4:0]  NormShifts = '0;
  logic [7:0]  ExpIn = '0;
  logic        SignIn = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] Result;
  logic        Overflow, Underflow, Inexact;
  int          n_chk = 0;
  int          n_fail = 0;
  typedef struct {
    logic [26:0] ar;
    logic        c;
    logic [4:0]  ns;
    logic [7:0]  e;
    logic        s;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec_t;
  vec_t v[12];
  fp_norm_round_stage dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .AdderResult(AdderResult), .EffCarry(EffCarry), .NormShifts(NormShifts),
    .ExpIn(ExpIn), .SignIn(SignIn), .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .Overflow(Overflow), .Underflow(Underflow), .Inexact(Inexact)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    AdderResult = x.ar;
    EffCarry    = x.c;
    NormShifts  = x.ns;
    ExpIn       = x.e;
    SignIn      = x.s;
    InValid     = 1'b1;
  endtask
  task automatic chk_out(input string tag, input vec_t x);
    chk({tag, " valid"}, {31'b0, OutValid}, 32'd1);
    chk({tag, " result"}, Result, x.res);
    chk({tag, " flags"}, {29'b0, Overflow, Underflow, Inexact}, {29'b0, x.fl});
  endtask
  initial begin
    v[0]  = '{27'h0000000, 1'b1, 5'd0,  8'd127, 1'b0, 32'h40000000, 3'b000};
    v[1]  = '{27'h0000008, 1'b0, 5'd23, 8'd127, 1'b0, 32'h34000000, 3'b000};
    v[2]  = '{27'h7FFFFFC, 1'b0, 5'd0,  8'd127, 1'b0, 32'h40000000, 3'b001};
    v[3]  = '{27'h0000000, 1'b1, 5'd0,  8'd254, 1'b0, 32'h7F800000, 3'b101};
    v[4]  = '{27'h0000000, 1'b0, 5'd24, 8'd127, 1'b0, 32'h00000000, 3'b000};
    v[5]  = '{27'h4000005, 1'b0, 5'd0,  8'd127, 1'b0, 32'h3F800001, 3'b001};
    v[6]  = '{27'h4000004, 1'b0, 5'd0,  8'd127, 1'b1, 32'hBF800000, 3'b001};
    v[7]  = '{27'h4000000, 1'b0, 5'd0,  8'd0,   1'b1, 32'h80000000, 3'b010};
    v[8]  = '{27'h0000003, 1'b0, 5'd24, 8'd100, 1'b1, 32'h00000000, 3'b001};
    v[9]  = '{27'h0000003, 1'b1, 5'd0,  8'd127, 1'b0, 32'h40000000, 3'b001};
    v[10] = '{27'h0000008, 1'b0, 5'd23, 8'd10,  1'b0, 32'h00000000, 3'b010};
    v[11] = '{27'h2000000, 1'b0, 5'd1,  8'd200, 1'b0, 32'h63800000, 3'b000};
    #1;
    chk("rst valid", {31'b0, OutValid}, 32'd0);
    chk("rst result", Result, 32'h0);
    chk("rst flags", {29'b0, Overflow, Underflow, Inexact}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post-rst inready", {31'b0, InReady}, 32'd1);
    chk("post-rst outvalid", {31'b0, OutValid}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(v[i]);
      @(posedge clk); #1;
      InValid = 1'b0;
      @(posedge clk); #1;
      chk_out($sformatf("v%0d", i), v[i]);
    end
    @(posedge clk); #1;
    chk("drained", {31'b0, OutValid}, 32'd0);
    @(negedge clk);
    OutReady = 1'b0;
    drive(v[0]);
    @(posedge clk); #1;
    drive(v[1]);
    chk("bp inready b2", {31'b0, InReady}, 32'd1);
    @(posedge clk); #1;
    drive(v[5]);
    chk("bp inready drop", {31'b0, InReady}, 32'd0);
    chk_out("bp A", v[0]);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp stall%0d result", k), Result, v[0].res);
      chk($sformatf("bp stall%0d inready", k), {31'b0, InReady}, 32'd0);
    end
    @(negedge clk);
    OutReady = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    chk_out("bp B", v[1]);
    @(posedge clk); #1;
    chk_out("bp C", v[5]);
    @(posedge clk); #1;
    chk("bp empty", {31'b0, OutValid}, 32'd0);
    @(negedge clk);
    drive(v[3]);
    @(posedge clk); #1;
    drive(v[11]);
    @(posedge clk); #1;
    InValid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid-rst outvalid", {31'b0, OutValid}, 32'd0);
    chk("mid-rst result", Result, 32'h0);
    chk("mid-rst flags", {29'b0, Overflow, Underflow, Inexact}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-mid-rst%0d outvalid", k), {31'b0, OutValid}, 32'd0);
      chk($sformatf("post-mid-rst%0d inready", k), {31'b0, InReady}, 32'd1);
    end
    @(negedge clk);
    drive(v[11]);
    @(posedge clk); #1;
    InValid = 1'b0;
    @(posedge clk); #1;
    chk_out("after-rst beat", v[11]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
